shared_mac_arbiter: RTL and testbench

SHARED_MAC_ARBITER -- requirements
Module: shared_mac_arbiter

---
 rtl/mac_arb_pkg.sv | 19 +
 rtl/mac_pipe.sv | 71 +++++++
 rtl/shared_mac_arbiter.sv | 175 +++++++++++++++++
 tb/tb_shared_mac_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_arb_pkg.sv
// mac_arb_pkg: shared types and constants for the shared MAC arbiter.
//   ACC_GUARD   : guard bits added above the full-width product in each accumulator
//   MAX_NUM_REQ : largest supported requester count
//   id_t        : requester index carried through the pipeline
//   tag_t       : sideband travelling alongside each product (id, first, last)
package mac_arb_pkg;

    localparam int unsigned ACC_GUARD   = 8;
    localparam int unsigned MAX_NUM_REQ = 8;

    typedef logic [2:0] id_t;

    typedef struct packed {
        id_t  id;
        logic first;
        logic last;
    } tag_t;

endpackage

// File: rtl/mac_pipe.sv
// mac_pipe: LATENCY-deep signed multiplier with valid and tag sideband.
// The product of the operands presented with in_valid_i appears on the outputs
// exactly LATENCY cycles later, together with its tag.
//   clk, reset     : clock, synchronous active-high reset (clears valid bits only)
//   in_valid_i     : beat accepted this cycle
//   in_a_i, in_b_i : signed operands, DATA_W bits each
//   in_tag_i       : id/first/last of the beat
//   out_valid_o    : product available this cycle
//   out_prod_o     : full-width signed product, 2*DATA_W bits
//   out_tag_o      : tag of the product
module mac_pipe
    import mac_arb_pkg::*;
#(
    parameter int unsigned DATA_W  = 24,
    parameter int unsigned LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid_i,
    input  logic [DATA_W-1:0]     in_a_i,
    input  logic [DATA_W-1:0]     in_b_i,
    input  tag_t                  in_tag_i,
    output logic                  out_valid_o,
    output logic [2*DATA_W-1:0]   out_prod_o,
    output tag_t                  out_tag_o
);

    localparam int unsigned PW = 2 * DATA_W;

    logic [LATENCY-1:0] valid_q, valid_d;
    logic [PW-1:0]      prod_q [LATENCY];
    logic [PW-1:0]      prod_d [LATENCY];
    tag_t               tag_q  [LATENCY];
    tag_t               tag_d  [LATENCY];
    logic signed [PW-1:0] a_ext, b_ext;

    always_comb begin
        // Sign-extend to full width so the truncated product is exact.
        a_ext      = {{DATA_W{in_a_i[DATA_W-1]}}, in_a_i};
        b_ext      = {{DATA_W{in_b_i[DATA_W-1]}}, in_b_i};
        valid_d[0] = in_valid_i;
        prod_d[0]  = a_ext * b_ext;
        tag_d[0]   = in_tag_i;
        for (int i = 1; i < LATENCY; i++) begin
            valid_d[i] = valid_q[i-1];
            prod_d[i]  = prod_q[i-1];
            tag_d[i]   = tag_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Data stages need no reset; they are qualified by valid_q.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LATENCY; i++) begin
            prod_q[i] <= prod_d[i];
            tag_q[i]  <= tag_d[i];
        end
    end

    assign out_valid_o = valid_q[LATENCY-1];
    assign out_prod_o  = prod_q[LATENCY-1];
    assign out_tag_o   = tag_q[LATENCY-1];

endmodule

// File: rtl/shared_mac_arbiter.sv
// shared_mac_arbiter: round-robin arbiter feeding one shared pipelined MAC,
// with one accumulator per requester.
// Optional feature: define MAC_ARB_STATS_EN to build per-requester grant counters.
//   clk, reset              : clock, synchronous active-high reset
//   req_valid_i/req_ready_o : per-requester beat handshake, ready one-hot or zero
//   req_a_i, req_b_i        : per-requester signed operands
//   req_first_i/req_last_i  : accumulation start / end markers
//   res_valid_o             : one-cycle pulse per completed accumulation
//   res_id_o, res_data_o    : requester index and signed accumulated result (held)
//   stat_grant_o            : per-requester grant counts (zero without the macro)
module shared_mac_arbiter
    import mac_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_W      = 24,
    parameter int unsigned MUL_LATENCY = 3
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_REQ-1:0]                     req_valid_i,
    output logic [NUM_REQ-1:0]                     req_ready_o,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]         req_a_i,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]         req_b_i,
    input  logic [NUM_REQ-1:0]                     req_first_i,
    input  logic [NUM_REQ-1:0]                     req_last_i,
    output logic                                   res_valid_o,
    output logic [2:0]                             res_id_o,
    output logic [2*DATA_W+ACC_GUARD-1:0]          res_data_o,
    output logic [NUM_REQ-1:0][31:0]               stat_grant_o
);

    localparam int unsigned PW    = 2 * DATA_W;
    localparam int unsigned ACC_W = PW + ACC_GUARD;

    id_t                rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] grant;
    id_t                grant_id;
    logic               grant_any;
    logic [DATA_W-1:0]  sel_a, sel_b;
    tag_t               sel_tag;

    // Two passes give the wrap-around search: first rr_ptr..NUM_REQ-1, then 0..rr_ptr-1.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!reset && !grant_any && req_valid_i[i] && i >= int'(rr_ptr_q)) begin
                grant[i]  = 1'b1;
                grant_id  = id_t'(i);
                grant_any = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!reset && !grant_any && req_valid_i[i] && i < int'(rr_ptr_q)) begin
                grant[i]  = 1'b1;
                grant_id  = id_t'(i);
                grant_any = 1'b1;
            end
        end
        rr_ptr_d = rr_ptr_q;
        if (grant_any) begin
            rr_ptr_d = (grant_id == id_t'(NUM_REQ - 1)) ? '0 : id_t'(grant_id + 3'd1);
        end
    end

    assign req_ready_o = grant;

    always_comb begin
        sel_a         = '0;
        sel_b         = '0;
        sel_tag.id    = grant_id;
        sel_tag.first = 1'b0;
        sel_tag.last  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_a         = req_a_i[i];
                sel_b         = req_b_i[i];
                sel_tag.first = req_first_i[i];
                sel_tag.last  = req_last_i[i];
            end
        end
    end

    logic          pipe_valid;
    logic [PW-1:0] pipe_prod;
    tag_t          pipe_tag;

    mac_pipe #(
        .DATA_W  (DATA_W),
        .LATENCY (MUL_LATENCY)
    ) u_mac_pipe (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (grant_any),
        .in_a_i      (sel_a),
        .in_b_i      (sel_b),
        .in_tag_i    (sel_tag),
        .out_valid_o (pipe_valid),
        .out_prod_o  (pipe_prod),
        .out_tag_o   (pipe_tag)
    );

    logic [ACC_W-1:0] acc_q [NUM_REQ];
    logic [ACC_W-1:0] acc_d [NUM_REQ];
    logic [ACC_W-1:0] prod_ext, acc_cur, acc_sum;
    logic             res_valid_q, res_valid_d;
    id_t              res_id_q, res_id_d;
    logic [ACC_W-1:0] res_data_q, res_data_d;

    // Accumulators update in one cycle, so back-to-back beats of one id need no forwarding.
    always_comb begin
        prod_ext = {{ACC_GUARD{pipe_prod[PW-1]}}, pipe_prod};
        acc_cur  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pipe_tag.id == id_t'(i)) begin
                acc_cur = acc_q[i];
            end
        end
        acc_sum = pipe_tag.first ? prod_ext : acc_cur + prod_ext;
        for (int i = 0; i < NUM_REQ; i++) begin
            acc_d[i] = (pipe_valid && pipe_tag.id == id_t'(i)) ? acc_sum : acc_q[i];
        end
        res_valid_d = pipe_valid && pipe_tag.last;
        res_id_d    = res_valid_d ? pipe_tag.id : res_id_q;
        res_data_d  = res_valid_d ? acc_sum : res_data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_data_q  <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_data_q  <= res_data_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    assign res_valid_o = res_valid_q;
    assign res_id_o    = res_id_q;
    assign res_data_o  = res_data_q;

`ifdef MAC_ARB_STATS_EN
    logic [NUM_REQ-1:0][31:0] stat_q, stat_d;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            stat_d[i] = stat_q[i] + {31'b0, grant[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_grant_o = stat_q;
`else
    assign stat_grant_o = '0;
`endif

endmodule

// File: tb/tb_shared_mac_arbiter.sv
// Self-checking bench for shared_mac_arbiter (NUM_REQ=4, DATA_W=24, MUL_LATENCY=3).
// A negedge monitor predicts arbitration and accumulation from the driven inputs,
// queues expected results with their due cycle, and checks them as they appear.
module tb_shared_mac_arbiter;

    localparam int NR  = 4;
    localparam int DW  = 24;
    localparam int LAT = 3;
    localparam int AW  = 2 * DW + 8;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [NR-1:0]          req_valid = '0;
    logic [NR-1:0]          req_first = '0;
    logic [NR-1:0]          req_last = '0;
    logic [NR-1:0][DW-1:0]  req_a = '0;
    logic [NR-1:0][DW-1:0]  req_b = '0;
    logic [NR-1:0]          req_ready;
    logic                   res_valid;
    logic [2:0]             res_id;
    logic [AW-1:0]          res_data;
    logic [NR-1:0][31:0]    stat;

    shared_mac_arbiter #(
        .NUM_REQ     (NR),
        .DATA_W      (DW),
        .MUL_LATENCY (LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .req_first_i  (req_first),
        .req_last_i   (req_last),
        .res_valid_o  (res_valid),
        .res_id_o     (res_id),
        .res_data_o   (res_data),
        .stat_grant_o (stat)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int            due;
        logic [2:0]    id;
        logic [AW-1:0] data;
    } exp_t;

    exp_t                 sb[$];
    exp_t                 e;
    logic signed [AW-1:0] m_acc [NR];
    int                   m_cnt [NR];
    int                   m_rr = 0;
    logic [2:0]           hold_id = '0;
    logic [AW-1:0]        hold_data = '0;
    logic [NR-1:0]        exp_rdy;
    int                   g;
    longint               pa, pb;

    // Reference model, evaluated mid-cycle.
    always @(negedge clk) begin
        exp_rdy = '0;
        g = -1;
        if (!reset) begin
            for (int k = 0; k < NR; k++) begin
                if (g < 0 && req_valid[(m_rr + k) % NR]) g = (m_rr + k) % NR;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("ready", req_ready, exp_rdy);

        for (int k = 0; k < NR; k++) begin
`ifdef MAC_ARB_STATS_EN
            chk("stat", stat[k], m_cnt[k]);
`else
            chk("stat", stat[k], 0);
`endif
        end

        while (sb.size() > 0 && sb[0].due < cyc) begin
            chk("res_late", cyc, sb[0].due);
            void'(sb.pop_front());
        end
        if (res_valid) begin
            if (sb.size() == 0) begin
                chk("res_unexpected", res_valid, 0);
            end else begin
                e = sb.pop_front();
                chk("res_cycle", cyc, e.due);
                chk("res_id", res_id, e.id);
                chk("res_data", res_data, e.data);
                hold_id   = e.id;
                hold_data = e.data;
            end
        end else begin
            chk("hold_id", res_id, hold_id);
            chk("hold_data", res_data, hold_data);
        end

        if (reset) begin
            sb.delete();
            m_rr      = 0;
            hold_id   = '0;
            hold_data = '0;
            for (int k = 0; k < NR; k++) begin
                m_acc[k] = '0;
                m_cnt[k] = 0;
            end
        end else if (g >= 0) begin
            pa = $signed(req_a[g]);
            pb = $signed(req_b[g]);
            m_acc[g] = req_first[g] ? AW'(pa * pb) : m_acc[g] + AW'(pa * pb);
            m_cnt[g]++;
            m_rr = (g + 1) % NR;
            if (req_last[g]) sb.push_back('{cyc + LAT + 1, 3'(g), m_acc[g]});
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one beat and holds it until accepted (bounded).
    task automatic send(input int k, input int a, input int b, input bit f, input bit l);
        bit done = 1'b0;
        req_a[k]     = DW'(a);
        req_b[k]     = DW'(b);
        req_first[k] = f;
        req_last[k]  = l;
        req_valid[k] = 1'b1;
        for (int n = 0; n < 32 && !done; n++) begin
            @(negedge clk);
            done = req_ready[k];
            @(posedge clk);
            #1;
        end
        req_valid[k] = 1'b0;
        chk("send_accept", done, 1);
    endtask

    logic          seen;
    logic [AW-1:0] exp_v;

    initial begin
        step(3);
        // Ready stays low during reset even with every requester valid.
        req_valid = '1;
        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_res_data", res_data, 0);
        for (int k = 0; k < NR; k++) chk("rst_stat", stat[k], 0);
        @(posedge clk);
        #1;
        req_valid = '0;
        reset = 1'b0;
        step(1);

        // Three-beat accumulation on requester 0: 12 - 10 + 7.
        send(0, 3, 4, 1, 0);
        send(0, -2, 5, 0, 0);
        send(0, 7, 1, 0, 1);
        step(LAT + 4);
        chk("mac_sum", res_data, 9);

        // first=0 continues from the retained accumulator.
        send(0, 2, 3, 0, 1);
        step(LAT + 4);
        chk("retained", res_data, 15);

        // Bring rr_ptr back to 0, then all four valid with single-beat accumulations.
        send(3, 1, 1, 1, 1);
        step(LAT + 4);
        for (int k = 0; k < NR; k++) begin
            req_a[k] = DW'(k + 1);
            req_b[k] = DW'(2);
        end
        req_first = '1;
        req_last  = '1;
        req_valid = '1;
        step(12);
        req_valid = '0;
        step(LAT + 4);

        // rr_ptr=2 with only requesters 1 and 3 active: 3, 1, 3.
        send(1, 4, 5, 1, 1);
        req_valid = 4'b1010;
        @(negedge clk);
        chk("rr_grant0", req_ready, 4'b1000);
        step(1);
        @(negedge clk);
        chk("rr_grant1", req_ready, 4'b0010);
        step(1);
        @(negedge clk);
        chk("rr_grant2", req_ready, 4'b1000);
        step(1);
        req_valid = '0;
        step(LAT + 4);

        // 256 back-to-back beats of the most negative operand.
        for (int n = 0; n < 256; n++) send(2, -8388608, -8388608, n == 0, n == 255);
        step(LAT + 4);
        chk("big_sum", res_data, 64'(1) << 54);

        // Reset two cycles after accepting a last beat: the result must vanish.
        send(1, 5, 6, 1, 1);
        step(1);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < LAT + 5; n++) begin
            @(negedge clk);
            seen = seen | res_valid;
        end
        chk("no_res_after_rst", seen, 0);
        step(1);

        // Accumulation from cleared accumulators (first=0 throughout), 10 grants to 2.
        for (int n = 0; n < 10; n++) send(2, 3, -7, 0, n == 9);
        step(LAT + 4);
        exp_v = AW'(-210);
        chk("post_rst_acc", res_data, exp_v);
        chk("post_rst_id", res_id, 2);
`ifdef MAC_ARB_STATS_EN
        chk("stat2", stat[2], 10);
`else
        chk("stat2", stat[2], 0);
`endif
        chk("stat0", stat[0], 0);
        chk("stat1", stat[1], 0);
        chk("stat3", stat[3], 0);

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
